// File: rtl/spi_flash_responder_pkg.sv
// Shared types and defaults for the SPI flash responder.
// Bit order is chosen in the top by SPI_RESPONDER_MSB_FIRST_EN (LSB first when undefined).
package spi_pkg;

  localparam int DATA_WIDTH = 8;
  localparam logic [DATA_WIDTH-1:0] IDLE_FILL = '1;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_state_t;

endpackage

// File: rtl/spi_flash_responder_if.sv
// Pin and local-side bundle for the SPI flash responder.
// The master modport is the controller plus the local logic; the slave modport is the responder.
interface spi_flash_responder_if #(
  parameter int DATA_WIDTH = spi_pkg::DATA_WIDTH
);

  logic                  sck;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;

  modport master (
    output sck, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun
  );

  modport slave (
    input  sck, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun
  );

endinterface

// File: rtl/spi_flash_responder_sync_edge.sv
// Two-flop synchronizer with a third flop for edge detection.
// RESET_VALUE is the idle level of the input, so reset never produces a false edge.
module spi_sync_edge #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= {3{RESET_VALUE}};
    end else begin
      sync <= {sync[1:0], d};
    end
  end

  assign level = sync[1];
  assign rise  = sync[1] & ~sync[2];
  assign fall  = ~sync[1] & sync[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder with an rx strobe and a one-entry tx holding register.
// Define SPI_RESPONDER_MSB_FIRST_EN to shift MSB first; the default build shifts LSB first.
module spi_flash_responder #(
  parameter int                            DATA_WIDTH = spi_pkg::DATA_WIDTH,
  parameter logic [spi_pkg::DATA_WIDTH-1:0] IDLE_FILL = spi_pkg::IDLE_FILL
) (
  input  logic                  clk,
  input  logic                  reset_n,
  spi_flash_responder_if.slave  bus
);

  import spi_pkg::*;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);
`ifdef SPI_RESPONDER_MSB_FIRST_EN
  localparam int FIRST_BIT = DATA_WIDTH - 1;
`else
  localparam int FIRST_BIT = 0;
`endif

  spi_state_t            state;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic [CNT_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] tx_word;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  miso;
  logic                  miso_oe;
  logic                  tx_underrun;
  logic                  word_start;

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [1:0] mosi_sync;
  logic unused_levels;

  spi_sync_edge #(.RESET_VALUE(1'b0)) u_sck_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.sck),
    .level   (sck_level),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_sync_edge #(.RESET_VALUE(1'b1)) u_cs_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.cs_n),
    .level   (cs_level),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  // Only the edges drive the state machine; the levels are kept for observability.
  assign unused_levels = sck_level ^ cs_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[0], bus.mosi};
    end
  end

`ifdef SPI_RESPONDER_MSB_FIRST_EN
  assign idx = LAST_BIT - bit_cnt;
`else
  assign idx = bit_cnt;
`endif

  always_comb begin
    rx_next      = rx_shift;
    rx_next[idx] = mosi_sync[1];
  end

  // A word offered in the same cycle as a word start bypasses the holding register.
  always_comb begin
    next_word = IDLE_FILL;
    if (hold_full) begin
      next_word = hold_reg;
    end else if (bus.tx_valid) begin
      next_word = bus.tx_data;
    end
  end

  assign word_start = ((state == IDLE) && cs_fall) ||
                      ((state == ACTIVE) && !cs_rise && sck_rise && (bit_cnt == LAST_BIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_word     <= '0;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      miso        <= 1'b1;
      miso_oe     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (word_start) begin
        tx_word     <= next_word;
        hold_full   <= 1'b0;
        tx_underrun <= !hold_full && !bus.tx_valid;
      end else if (bus.tx_valid && !hold_full) begin
        hold_reg  <= bus.tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ACTIVE;
            bit_cnt <= '0;
            miso    <= next_word[FIRST_BIT];
            miso_oe <= 1'b1;
          end
        end
        ACTIVE: begin
          // Deselect wins over any sck edge and drops a partial word.
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            miso    <= 1'b1;
            miso_oe <= 1'b0;
          end else if (sck_rise) begin
            if (bit_cnt == LAST_BIT) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else if (sck_fall) begin
            miso <= tx_word[idx];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.miso        = miso;
  assign bus.miso_oe     = miso_oe;
  assign bus.tx_ready    = !hold_full;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.tx_underrun = tx_underrun;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: an SPI controller model drives frames,
// a transaction-level model predicts rx words, miso words and underruns.
`timescale 1ns/1ps
module tb_spi_flash_responder;

  localparam int DW = 8;
  localparam logic [DW-1:0] FILL = 8'hFF;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_flash_responder_if #(.DATA_WIDTH(DW)) bus ();

  spi_flash_responder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int exp_underrun = 0;
  int obs_underrun = 0;

  logic [DW-1:0] pend_q[$];
  logic [DW-1:0] miso_q[$];
  logic [DW-1:0] rx_q[$];

  logic [DW-1:0] rxw [6];
  logic [DW-1:0] txw [6];
  bit            give [6];
  bit            sim_entry = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  function automatic int bit_pos(input int b);
`ifdef SPI_RESPONDER_MSB_FIRST_EN
    return DW - 1 - b;
`else
    return b;
`endif
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every word start takes the oldest queued word, or the idle fill plus an underrun.
  task automatic model_word_start(input bit complete);
    logic [DW-1:0] w;
    if (pend_q.size() > 0) begin
      w = pend_q.pop_front();
    end else begin
      w = FILL;
      exp_underrun++;
    end
    if (complete) miso_q.push_back(w);
  endtask

  task automatic queue_tx(input logic [DW-1:0] word);
    int budget;
    budget = 40;
    bus.tx_data  = word;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check_output("tx_handshake", 32'(bus.tx_ready), 1);
    else pend_q.push_back(word);
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input int n_full, input int partial, input bit do_reset);
    int total;
    int bits;
    total = n_full + ((partial > 0) ? 1 : 0);
    if (give[0] && !sim_entry) queue_tx(txw[0]);
    @(negedge clk);
    bus.cs_n = 1'b0;
    if (sim_entry) begin
      wait_clks(2);
      bus.tx_data  = txw[0];
      bus.tx_valid = 1'b1;
      pend_q.push_back(txw[0]);
      model_word_start(n_full > 0);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      check_output("tx_ready_simultaneous", 32'(bus.tx_ready), 1);
    end else begin
      model_word_start(n_full > 0);
    end
    wait_clks(HALF);
    for (int w = 0; w < total; w++) begin
      bits = (w < n_full) ? DW : partial;
      for (int b = 0; b < bits; b++) begin
        bus.mosi = rxw[w][bit_pos(b)];
        wait_clks(HALF);
        bus.sck = 1'b1;
        if (b == DW - 1) begin
          rx_q.push_back(rxw[w]);
          model_word_start(w + 1 < n_full);
        end
        wait_clks(HALF);
        bus.sck = 1'b0;
        if (b == 3 && give[w + 1]) queue_tx(txw[w + 1]);
      end
    end
    wait_clks(HALF);
    if (do_reset) begin
      reset_n = 1'b0;
      #1;
      check_output("reset_miso", 32'(bus.miso), 1);
      check_output("reset_miso_oe", 32'(bus.miso_oe), 0);
      check_output("reset_tx_ready", 32'(bus.tx_ready), 1);
      check_output("reset_rx_data", 32'(bus.rx_data), 0);
      check_output("reset_rx_valid", 32'(bus.rx_valid), 0);
      check_output("reset_tx_underrun", 32'(bus.tx_underrun), 0);
      pend_q.delete();
      @(negedge clk);
    end
    bus.cs_n = 1'b1;
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(2 * HALF);
    check_output("miso_oe_idle", 32'(bus.miso_oe), 0);
    check_output("rx_words_outstanding", 32'(rx_q.size()), 0);
    check_output("miso_words_outstanding", 32'(miso_q.size()), 0);
    check_output("underrun_count", 32'(obs_underrun), 32'(exp_underrun));
    check_output("tx_ready_after_frame", 32'(bus.tx_ready), 32'(pend_q.size() == 0));
    sim_entry = 1'b0;
    for (int i = 0; i < 6; i++) give[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.tx_underrun) obs_underrun++;
    if (bus.rx_valid) begin
      if (rx_q.size() == 0) check_output("rx_valid_unexpected", 32'(rx_q.size()), 1);
      else check_output("rx_word", 32'(bus.rx_data), 32'(rx_q.pop_front()));
    end
  end

  initial begin : miso_monitor
    int nbits;
    logic [DW-1:0] word;
    nbits = 0;
    word = '0;
    forever begin
      @(posedge bus.sck or posedge bus.cs_n);
      if (bus.cs_n) begin
        nbits = 0;
      end else begin
        check_output("miso_oe_active", 32'(bus.miso_oe), 1);
        word[bit_pos(nbits)] = bus.miso;
        nbits++;
        if (nbits == DW) begin
          nbits = 0;
          if (miso_q.size() == 0) check_output("miso_word_unexpected", 32'(miso_q.size()), 1);
          else check_output("miso_word", 32'(word), 32'(miso_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.sck      = 1'b0;
    bus.cs_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    for (int i = 0; i < 6; i++) begin
      give[i] = 1'b0;
      rxw[i]  = '0;
      txw[i]  = '0;
    end
    wait_clks(3);
    check_output("init_miso", 32'(bus.miso), 1);
    check_output("init_miso_oe", 32'(bus.miso_oe), 0);
    check_output("init_tx_ready", 32'(bus.tx_ready), 1);
    check_output("init_rx_data", 32'(bus.rx_data), 0);
    check_output("init_rx_valid", 32'(bus.rx_valid), 0);
    check_output("init_tx_underrun", 32'(bus.tx_underrun), 0);
    reset_n = 1'b1;
    wait_clks(4);

    $display("[TB] single word");
    rxw[0] = 8'h3C; txw[0] = 8'hA5; give[0] = 1'b1;
    apply_stimulus(1, 0, 1'b0);

    $display("[TB] underrun");
    rxw[0] = 8'h5A;
    apply_stimulus(1, 0, 1'b0);

    $display("[TB] back-to-back");
    rxw[0] = 8'hC3; rxw[1] = 8'h96; rxw[2] = 8'h0F;
    txw[0] = 8'h11; txw[1] = 8'h22; txw[2] = 8'h33;
    give[0] = 1'b1; give[1] = 1'b1; give[2] = 1'b1;
    apply_stimulus(3, 0, 1'b0);

    $display("[TB] abort after 5 bits");
    rxw[0] = 8'h77; txw[0] = 8'h44; txw[1] = 8'h5E;
    give[0] = 1'b1; give[1] = 1'b1;
    apply_stimulus(0, 5, 1'b0);
    rxw[0] = 8'h81;
    apply_stimulus(1, 0, 1'b0);

    $display("[TB] word offered at the word start");
    rxw[0] = 8'hE1; txw[0] = 8'h6C; give[0] = 1'b1; sim_entry = 1'b1;
    apply_stimulus(1, 0, 1'b0);

    $display("[TB] reset mid-frame");
    rxw[0] = 8'hF0; txw[0] = 8'h99; give[0] = 1'b1;
    apply_stimulus(0, 3, 1'b1);
    rxw[0] = 8'hD2; txw[0] = 8'h3A; give[0] = 1'b1;
    apply_stimulus(1, 0, 1'b0);

    $display("[TB] bit order");
    rxw[0] = 8'h80; txw[0] = 8'h01; give[0] = 1'b1;
    apply_stimulus(1, 0, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 10; f++) begin
      int n_full;
      int partial;
      n_full  = int'($urandom_range(1, 3));
      partial = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int i = 0; i < 6; i++) begin
        rxw[i]  = DW'($urandom);
        txw[i]  = DW'($urandom);
        give[i] = 1'($urandom_range(0, 1));
      end
      if (pend_q.size() != 0) give[0] = 1'b0;
      sim_entry = give[0] && ($urandom_range(0, 3) == 0);
      apply_stimulus(n_full, partial, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
